// File: rtl/m_div_control.sv
// Control FSM for an iterative radix-2 32-bit divider: sequences an external R/D/Z
// register block, short-circuits divide-by-zero and signed overflow, and fixes result sign.
`ifndef M_DEFINITIONS_SVH
`define M_DEFINITIONS_SVH
`define MUX_R_LENGTH   2
`define MUX_R_KEEP     2'd0
`define MUX_R_A        2'd1
`define MUX_R_A_NEG    2'd2
`define MUX_R_SUB_KEEP 2'd3
`define MUX_D_LENGTH   2
`define MUX_D_KEEP     2'd0
`define MUX_D_B        2'd1
`define MUX_D_B_NEG    2'd2
`define MUX_D_SHR      2'd3
`define MUX_Z_LENGTH   2
`define MUX_Z_KEEP     2'd0
`define MUX_Z_ZERO     2'd1
`define MUX_Z_SHL_ADD  2'd2
`endif

module m_div_control (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [31:0]              rs1,
  input  logic [31:0]              rs2,
  input  logic                     sub_neg,
  input  logic [31:0]              R,
  input  logic [31:0]              Z,
  output logic [`MUX_R_LENGTH-1:0] mux_R,
  output logic [`MUX_D_LENGTH-1:0] mux_D,
  output logic [`MUX_Z_LENGTH-1:0] mux_Z,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              result
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned ITERS = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
  typedef enum logic [1:0] {K_NORMAL, K_DIVZ, K_OVF} kind_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_rs1;
  logic              r_sign_q;
  logic              r_sign_r;
  kind_t             r_kind;

  logic              w_signed;
  logic              w_divz;
  logic              w_ovf;
  logic              w_accept;
  kind_t             w_kind;
  logic              w_is_rem;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_res;
  logic              w_unused;

  // The subtractor sign steers the external register block directly; control ignores it.
  assign w_unused = ^{1'b0, sub_neg};

  assign w_signed = (op == OP_DIV) || (op == OP_REM);
  assign w_divz   = (rs2 == '0);
  assign w_ovf    = w_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign w_kind   = w_divz ? K_DIVZ : (w_ovf ? K_OVF : K_NORMAL);
  // Gating with resetn keeps the load selects at KEEP while reset is held.
  assign w_accept = resetn && (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_kind == K_NORMAL) ? S_ITER : S_DONE;
      S_ITER:  if (r_cnt == CNT_W'(ITERS - 1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch and iteration counter; start outside IDLE leaves these untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_rs1    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_kind   <= K_NORMAL;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_op     <= op;
      r_rs1    <= rs1;
      r_sign_q <= w_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
      r_sign_r <= w_signed && rs1[XLEN-1];
      r_kind   <= w_kind;
    end else if (r_state == S_ITER) begin
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // Sign fix-up wraps, so negating 0x80000000 stays 0x80000000.
  assign w_is_rem = (r_op == OP_REM) || (r_op == OP_REMU);
  assign w_quo    = r_sign_q ? (~Z + XLEN'(1)) : Z;
  assign w_rem    = r_sign_r ? (~R + XLEN'(1)) : R;

  always_comb begin
    w_res = w_is_rem ? w_rem : w_quo;
    case (r_kind)
      K_DIVZ:  w_res = w_is_rem ? r_rs1 : 32'hFFFF_FFFF;
      K_OVF:   w_res = w_is_rem ? 32'h0000_0000 : 32'h8000_0000;
      default: w_res = w_is_rem ? w_rem : w_quo;
    endcase
  end

  always_comb begin
    mux_R  = `MUX_R_KEEP;
    mux_D  = `MUX_D_KEEP;
    mux_Z  = `MUX_Z_KEEP;
    busy   = 1'b0;
    done   = 1'b0;
    result = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (w_kind == K_NORMAL)) begin
          mux_R = (w_signed && rs1[XLEN-1]) ? `MUX_R_A_NEG : `MUX_R_A;
          mux_D = (w_signed && rs2[XLEN-1]) ? `MUX_D_B_NEG : `MUX_D_B;
          mux_Z = `MUX_Z_ZERO;
        end
      end
      S_ITER: begin
        mux_R = `MUX_R_SUB_KEEP;
        mux_D = `MUX_D_SHR;
        mux_Z = `MUX_Z_SHL_ADD;
        busy  = 1'b1;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        result = w_res;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_m_div_control.sv
// Scoreboard bench for m_div_control with a behavioural R/D/Z register block model.
`ifndef M_DEFINITIONS_SVH
`define M_DEFINITIONS_SVH
`define MUX_R_LENGTH   2
`define MUX_R_KEEP     2'd0
`define MUX_R_A        2'd1
`define MUX_R_A_NEG    2'd2
`define MUX_R_SUB_KEEP 2'd3
`define MUX_D_LENGTH   2
`define MUX_D_KEEP     2'd0
`define MUX_D_B        2'd1
`define MUX_D_B_NEG    2'd2
`define MUX_D_SHR      2'd3
`define MUX_Z_LENGTH   2
`define MUX_Z_KEEP     2'd0
`define MUX_Z_ZERO     2'd1
`define MUX_Z_SHL_ADD  2'd2
`endif

module tb_m_div_control;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        sub_neg;
  logic [31:0] R;
  logic [31:0] Z;
  logic [`MUX_R_LENGTH-1:0] mux_R;
  logic [`MUX_D_LENGTH-1:0] mux_D;
  logic [`MUX_Z_LENGTH-1:0] mux_Z;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned t_last  = 0;
  int unsigned t0      = 0;

  logic [31:0] sb_res[$];
  int unsigned sb_due[$];
  string       sb_name[$];
  logic [31:0] mon_res;
  int unsigned mon_due;
  string       mon_name;

  // Register block model: 64-bit remainder, divisor pre-shifted by 31, quotient shift-in.
  logic [63:0] dp_r = '0;
  logic [63:0] dp_d = '0;
  logic [31:0] dp_z = '0;

  always #5 clk = ~clk;

  m_div_control dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .sub_neg(sub_neg), .R(R), .Z(Z), .mux_R(mux_R), .mux_D(mux_D), .mux_Z(mux_Z),
    .busy(busy), .done(done), .result(result)
  );

  assign sub_neg = (dp_r < dp_d);
  assign R = dp_r[31:0];
  assign Z = dp_z;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    case (mux_R)
      `MUX_R_A:        dp_r <= {32'b0, rs1};
      `MUX_R_A_NEG:    dp_r <= {32'b0, 32'(~rs1 + 32'd1)};
      `MUX_R_SUB_KEEP: if (!sub_neg) dp_r <= dp_r - dp_d;
      default: ;
    endcase
    case (mux_D)
      `MUX_D_B:     dp_d <= {1'b0, rs2, 31'b0};
      `MUX_D_B_NEG: dp_d <= {1'b0, 32'(~rs2 + 32'd1), 31'b0};
      `MUX_D_SHR:   dp_d <= dp_d >> 1;
      default: ;
    endcase
    case (mux_Z)
      `MUX_Z_ZERO:    dp_z <= '0;
      `MUX_Z_SHL_ADD: dp_z <= {dp_z[30:0], ~sub_neg};
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation and its cycle.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_tests++;
      if (sb_res.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done=1 result=0x%08h at cycle %0d, expected no done", result, cyc);
      end else begin
        mon_res  = sb_res.pop_front();
        mon_due  = sb_due.pop_front();
        mon_name = sb_name.pop_front();
        if (result !== mon_res) begin
          n_fail++;
          $display("FAIL %s_result: got 0x%08h, expected 0x%08h", mon_name, result, mon_res);
        end
        check({mon_name, "_cycle"}, 32'(cyc), 32'(mon_due));
      end
    end else begin
      check("result_zero_when_idle", result, 32'h0);
    end
  end

  task automatic goto(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_start(input string name, input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [1:0] er, input logic [1:0] ed,
                             input logic [1:0] ez);
    start = 1'b1; op = o; rs1 = a; rs2 = b; t_last = cyc;
    #1;
    check({name, "_mux_r"}, 32'(mux_R), 32'(er));
    check({name, "_mux_d"}, 32'(mux_D), 32'(ed));
    check({name, "_mux_z"}, 32'(mux_Z), 32'(ez));
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
  endtask

  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int unsigned lat,
                       input logic [1:0] er, input logic [1:0] ed, input logic [1:0] ez);
    @(posedge clk); #1;
    sb_res.push_back(exp);
    sb_due.push_back(cyc + lat);
    sb_name.push_back(name);
    drive_start(name, o, a, b, er, ed, ez);
  endtask

  task automatic chk_iter(input string name);
    check({name, "_iter_mux_r"}, 32'(mux_R), 32'(`MUX_R_SUB_KEEP));
    check({name, "_iter_mux_d"}, 32'(mux_D), 32'(`MUX_D_SHR));
    check({name, "_iter_mux_z"}, 32'(mux_Z), 32'(`MUX_Z_SHL_ADD));
    check({name, "_iter_busy"}, 32'(busy), 32'h1);
  endtask

  task automatic chk_done_keep(input string name);
    check({name, "_done_mux_r"}, 32'(mux_R), 32'(`MUX_R_KEEP));
    check({name, "_done_mux_d"}, 32'(mux_D), 32'(`MUX_D_KEEP));
    check({name, "_done_mux_z"}, 32'(mux_Z), 32'(`MUX_Z_KEEP));
    check({name, "_done_busy"}, 32'(busy), 32'h1);
  endtask

  task automatic wait_empty(input int unsigned budget);
    int unsigned n = 0;
    while (sb_res.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (sb_res.size() != 0) begin
      n_fail++;
      $display("FAIL timeout: got %0d pending results after %0d cycles, expected 0", sb_res.size(), budget);
      sb_res.delete(); sb_due.delete(); sb_name.delete();
    end
  endtask

  task automatic chk_reset(input string name);
    check({name, "_busy"}, 32'(busy), 32'h0);
    check({name, "_done"}, 32'(done), 32'h0);
    check({name, "_result"}, result, 32'h0);
    check({name, "_mux_r"}, 32'(mux_R), 32'(`MUX_R_KEEP));
    check({name, "_mux_d"}, 32'(mux_D), 32'(`MUX_D_KEEP));
    check({name, "_mux_z"}, 32'(mux_Z), 32'(`MUX_Z_KEEP));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 time units, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Start held during reset must not reach the selects.
    start = 1'b1; op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    #2;
    chk_reset("power_on_reset");
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;

    issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, `MUX_R_A, `MUX_D_B, `MUX_Z_ZERO);
    chk_iter("divu_100_7");
    wait_empty(40);
    issue("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, `MUX_R_A, `MUX_D_B, `MUX_Z_ZERO);
    wait_empty(40);
    issue("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, `MUX_R_A_NEG, `MUX_D_B, `MUX_Z_ZERO);
    wait_empty(40);
    issue("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, `MUX_R_A_NEG, `MUX_D_B, `MUX_Z_ZERO);
    wait_empty(40);
    issue("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, `MUX_R_A, `MUX_D_B_NEG, `MUX_Z_ZERO);
    wait_empty(40);
    issue("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, `MUX_R_A, `MUX_D_B, `MUX_Z_ZERO);
    wait_empty(40);

    issue("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, `MUX_R_KEEP, `MUX_D_KEEP, `MUX_Z_KEEP);
    chk_done_keep("divu_5_0");
    wait_empty(10);
    issue("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, `MUX_R_KEEP, `MUX_D_KEEP, `MUX_Z_KEEP);
    chk_done_keep("rem_m5_0");
    wait_empty(10);
    issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, `MUX_R_KEEP, `MUX_D_KEEP, `MUX_Z_KEEP);
    chk_done_keep("div_ovf");
    wait_empty(10);
    issue("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, `MUX_R_KEEP, `MUX_D_KEEP, `MUX_Z_KEEP);
    wait_empty(10);
    issue("divu_no_ovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, `MUX_R_A, `MUX_D_B, `MUX_Z_ZERO);
    wait_empty(40);

    // Start during the DONE cycle of a short-circuit op is ignored.
    issue("divu_9_0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, `MUX_R_KEEP, `MUX_D_KEEP, `MUX_Z_KEEP);
    drive_start("ignored_in_done", OP_DIVU, 32'd20, 32'd4, `MUX_R_KEEP, `MUX_D_KEEP, `MUX_Z_KEEP);
    wait_empty(10);
    issue("remu_20_6", OP_REMU, 32'd20, 32'd6, 32'd2, 33, `MUX_R_A, `MUX_D_B, `MUX_Z_ZERO);
    wait_empty(40);

    // Start while busy is ignored; back-to-back start in the IDLE right after DONE.
    issue("b2b_first", OP_DIVU, 32'd1000, 32'd10, 32'd100, 33, `MUX_R_A, `MUX_D_B, `MUX_Z_ZERO);
    t0 = t_last;
    goto(t0 + 5);
    drive_start("ignored_busy", OP_DIV, 32'hFFFF_FF00, 32'd3, `MUX_R_SUB_KEEP, `MUX_D_SHR, `MUX_Z_SHL_ADD);
    goto(t0 + 33);
    issue("b2b_second", OP_REMU, 32'd1000, 32'd7, 32'd6, 33, `MUX_R_A, `MUX_D_B, `MUX_Z_ZERO);
    wait_empty(80);

    // Reset mid-iteration: outputs drop at once and no done pulse follows.
    @(posedge clk); #1;
    drive_start("rst_victim", OP_DIVU, 32'd50, 32'd3, `MUX_R_A, `MUX_D_B, `MUX_Z_ZERO);
    t0 = t_last;
    goto(t0 + 10);
    resetn = 1'b0;
    #1;
    chk_reset("mid_iter_reset");
    goto(t0 + 12);
    resetn = 1'b1;
    goto(t0 + 60);
    issue("after_reset", OP_DIVU, 32'd50, 32'd3, 32'd16, 33, `MUX_R_A, `MUX_D_B, `MUX_Z_ZERO);
    chk_iter("after_reset");
    wait_empty(40);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m_div_control.md
M_DIV_CONTROL -- requirements
Module: m_div_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
REQ-005 SHALL have ports rs1 and rs2, input, 32 bits each: dividend and divisor; valid only in the start cycle.
REQ-006 SHALL have port sub_neg, input, 1 bit: external subtractor result (R - D) is negative.
REQ-007 SHALL have ports R and Z, input, 32 bits each: remainder and quotient register contents.
REQ-008 SHALL have ports mux_R, mux_D and mux_Z, outputs of widths `MUX_R_LENGTH, `MUX_D_LENGTH and `MUX_Z_LENGTH: register-block selects using the m_definitions.svh codes.
REQ-009 SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 SHALL have port done, output, 1 bit: single-cycle result-valid pulse.
REQ-011 SHALL have port result, output, 32 bits: valid only while done=1, else 0.

Function
REQ-012 States SHALL be IDLE, ITER, DONE; 5-bit iteration counter cnt.
REQ-013 IDLE with start=0: mux_R=KEEP, mux_D=KEEP, mux_Z=KEEP; busy=0.
REQ-014 Start accepted at edge T (IDLE, start=1) SHALL latch op, rs1, sign_q and sign_r.
- sign_q = signed & (rs1[31]^rs2[31]).
- sign_r = signed & rs1[31].
- signed = (op==DIV | op==REM).
REQ-015 Start cycle, normal case, SHALL drive the load selects combinationally and go to ITER with cnt=0.
- mux_R = A_NEG if signed & rs1[31], else A.
- mux_D = B_NEG if signed & rs2[31], else B.
- mux_Z = ZERO.
REQ-016 ITER SHALL drive mux_R=SUB_KEEP, mux_D=SHR, mux_Z=SHL_ADD; cnt increments each cycle; after cnt==31 go to DONE (exactly 32 ITER cycles).
REQ-017 DONE SHALL assert done=1 for one cycle, then return to IDLE with all selects KEEP.
- DIV/DIVU: result = Z, negated if sign_q.
- REM/REMU: result = R, negated if sign_r.
REQ-018 Normal latency SHALL be done at cycle T+33, counting the start cycle as T; busy=1 from T+1 through T+33.
REQ-019 Divide-by-zero (rs2==0) SHALL skip ITER: start cycle drives all selects KEEP, next state DONE, done at T+1.
- DIV/DIVU: result = 0xFFFFFFFF.
- REM/REMU: result = latched rs1.
REQ-020 Signed overflow (op DIV or REM, rs1==0x80000000, rs2==0xFFFFFFFF) SHALL skip ITER, done at T+1.
- DIV: result = 0x80000000.
- REM: result = 0.
REQ-021 Divide-by-zero SHALL take priority over overflow; neither path SHALL depend on R, Z or sub_neg.
REQ-022 start while busy=1, or in DONE, SHALL be ignored with no effect on state, selects or latched operands.
REQ-023 start may be asserted in the IDLE cycle immediately after DONE: back-to-back throughput SHALL be one operation per 34 cycles.
REQ-024 Negation SHALL be 32-bit two's complement (wrap): negating 0x80000000 yields 0x80000000.

Reset
REQ-025 resetn=0 SHALL asynchronously force the following, at any time including mid-ITER.
- state=IDLE, cnt=0, latched fields 0.
- busy=0, done=0, result=0.
- mux_R/mux_D/mux_Z = KEEP.
REQ-026 An interrupted operation SHALL never produce done; the first start after reset release SHALL behave as from power-up.

Verification
REQ-027 DIVU 100/7 -> done at T+33, result 14; REMU 100/7 -> result 2.
REQ-028 DIV -7/2 (0xFFFFFFF9, 2) -> result 0xFFFFFFFD; REM -7/2 -> result 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD.
REQ-029 DIVU 5/0 -> done at T+1, result 0xFFFFFFFF; REM 0xFFFFFFFB/0 -> result 0xFFFFFFFB; no ITER selects seen.
REQ-030 DIV 0x80000000/0xFFFFFFFF -> done at T+1, result 0x80000000; REM same operands -> result 0.
REQ-031 Cases below -> first op completes correctly; second op done at exactly T2+33, where T2 is its own start cycle.
- start re-asserted at T+5 with different operands -> ignored.
- start asserted in the IDLE cycle at T+34 -> accepted.
REQ-032 resetn pulsed low at T+10 -> busy=0, done=0, all selects KEEP immediately; no done pulse follows.
